// File: rtl/udma_uart_tx_arb.sv
// Round-robin, burst-locking arbiter that merges N_REQ byte streams into one UART TX stream.
// A granted source keeps the stream until its last byte, the burst cap, or its enable drops.
module udma_uart_tx_arb #(
    parameter int N_REQ   = 2,
    parameter int BURST_W = 8,
    parameter int IDX_W   = $clog2(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     cfg_en_i,
    input  logic [BURST_W-1:0]   cfg_max_burst_i,
    input  logic [N_REQ*8-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic [IDX_W-1:0]     tx_src_o,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o
);

    localparam logic [0:0] STATE_IDLE   = 1'b0;
    localparam logic [0:0] STATE_LOCKED = 1'b1;
    localparam int         SW           = IDX_W + 2;

    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [0:0]         state_p0;
    logic [N_REQ-1:0]   grant_p0;
    logic [IDX_W-1:0]   gidx_p0;
    logic [IDX_W-1:0]   ptr_p0;
    logic [BURST_W-1:0] cnt_p0;

    logic [7:0]         data_p1;
    logic [IDX_W-1:0]   src_p1;
    logic               vld_p1;

    logic [N_REQ-1:0]   eligible;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [SW-1:0]      cand;

    logic               locked;
    logic               out_free;
    logic               g_en;
    logic               g_valid;
    logic               g_last;
    logic [7:0]         g_byte;
    logic               g_ready;
    logic               accept;
    logic [BURST_W-1:0] cnt_inc;
    logic               cap_hit;
    logic               release_lock;

    assign eligible = req_valid_i & cfg_en_i;

    // Search starts just after the last released source so every source gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = SW'(ptr_p0) + SW'(i) + SW'(1);
            if (cand >= SW'(N_REQ)) begin
                cand = cand - SW'(N_REQ);
            end
            if (!win_found && eligible[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        g_en    = 1'b0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_byte  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx_p0 == IDX_W'(i)) begin
                g_en    = cfg_en_i[i];
                g_valid = req_valid_i[i];
                g_last  = req_last_i[i];
                g_byte  = req_data_i[8*i +: 8];
            end
        end
    end

    assign locked       = (state_p0 == STATE_LOCKED);
    assign out_free     = ~vld_p1 | tx_ready_i;
    assign g_ready      = locked & g_en & out_free;
    assign accept       = g_ready & g_valid;
    assign cnt_inc      = sat_inc(cnt_p0);
    // Compare with >= so a cap lowered below the running count ends the burst on the next byte.
    assign cap_hit      = (cfg_max_burst_i != '0) && (cnt_inc >= cfg_max_burst_i);
    assign release_lock = locked & (~g_en | (accept & (g_last | cap_hit)));

    // Stage p0: arbitration / lock state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_p0 <= STATE_IDLE;
            grant_p0 <= '0;
            gidx_p0  <= '0;
            ptr_p0   <= IDX_W'(N_REQ - 1);
            cnt_p0   <= '0;
        end else begin
            case (state_p0)
                STATE_IDLE: begin
                    if (win_found) begin
                        state_p0 <= STATE_LOCKED;
                        grant_p0 <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        gidx_p0  <= win_idx;
                        cnt_p0   <= '0;
                    end
                end
                default: begin
                    if (release_lock) begin
                        state_p0 <= STATE_IDLE;
                        grant_p0 <= '0;
                        cnt_p0   <= '0;
                        ptr_p0   <= gidx_p0;
                    end else if (accept) begin
                        cnt_p0 <= cnt_inc;
                    end
                end
            endcase
        end
    end

    // Stage p1: output byte register, drains independently of the lock
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            src_p1  <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            data_p1 <= g_byte;
            src_p1  <= gidx_p0;
        end else if (tx_ready_i) begin
            vld_p1  <= 1'b0;
        end
    end

    assign req_ready_o = g_ready ? grant_p0 : '0;
    assign grant_o     = grant_p0;
    assign tx_data_o   = data_p1;
    assign tx_src_o    = src_p1;
    assign tx_valid_o  = vld_p1;
    assign busy_o      = locked | vld_p1;

endmodule

// File: tb/tb_udma_uart_tx_arb.sv
// Directed bench for udma_uart_tx_arb with three requesters; expected values are hand-derived
// cycle by cycle (C0 = first cycle after reset release, the arbitration cycle).
module tb_udma_uart_tx_arb;

    localparam int N_REQ   = 3;
    localparam int BURST_W = 8;
    localparam int IDX_W   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_REQ-1:0]     cfg_en;
    logic [BURST_W-1:0]   cap;
    logic [N_REQ*8-1:0]   req_data;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_last;
    logic [N_REQ-1:0]     req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [IDX_W-1:0]     tx_src;
    logic [N_REQ-1:0]     grant;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int nbytes;

    udma_uart_tx_arb #(.N_REQ(N_REQ), .BURST_W(BURST_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cfg_en_i       (cfg_en),
        .cfg_max_burst_i(cap),
        .req_data_i     (req_data),
        .req_valid_i    (req_valid),
        .req_last_i     (req_last),
        .req_ready_o    (req_ready),
        .tx_data_o      (tx_data),
        .tx_valid_o     (tx_valid),
        .tx_ready_i     (tx_ready),
        .tx_src_o       (tx_src),
        .grant_o        (grant),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " grant"},    32'(grant),     0);
        check({tag, " ready"},    32'(req_ready), 0);
        check({tag, " tx_valid"}, 32'(tx_valid),  0);
        check({tag, " tx_data"},  32'(tx_data),   0);
        check({tag, " tx_src"},   32'(tx_src),    0);
        check({tag, " busy"},     32'(busy),      0);
    endtask

    int         t2_grant [12] = '{1, 1, 0, 2, 2, 0, 4, 4, 0, 1, 1, 0};
    int         t2_vld   [12] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    int         t2_src   [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0};

    logic       t3_rdy   [11] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    logic [7:0] t3_din   [11] = '{8'h40, 8'h41, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42, 8'h43, 8'h43, 8'h43};
    logic       t3_last  [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic       t3_val   [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    int         t3_evld  [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int         t3_edat  [11] = '{0, 8'h40, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h42, 8'h43, 0};
    int         t3_erdy  [11] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    int         t3_egnt  [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};

    initial begin
        cfg_en    = 3'b111;
        cap       = '0;
        req_data  = '0;
        req_valid = 3'b011;
        req_last  = '0;
        tx_ready  = 1'b1;
        req_data[7:0]  = 8'hA0;
        req_data[15:8] = 8'hB0;

        // Reset state
        settle();
        check_all_zero("reset");
        next_cycle();
        rst = 1'b0;

        // Test 1: req0 then req1, cap 0
        settle();
        check("t1 c0 grant", 32'(grant), 0);
        check("t1 c0 ready", 32'(req_ready), 0);
        next_cycle();
        settle();
        check("t1 c1 grant", 32'(grant), 1);
        check("t1 c1 ready", 32'(req_ready), 1);
        check("t1 c1 tx_valid", 32'(tx_valid), 0);
        next_cycle();
        req_data[7:0] = 8'hA1;
        settle();
        check("t1 c2 tx_valid", 32'(tx_valid), 1);
        check("t1 c2 tx_data", 32'(tx_data), 8'hA0);
        check("t1 c2 tx_src", 32'(tx_src), 0);
        next_cycle();
        req_data[7:0] = 8'hA2;
        req_last = 3'b001;
        settle();
        check("t1 c3 tx_data", 32'(tx_data), 8'hA1);
        next_cycle();
        req_last = 3'b000;
        settle();
        check("t1 c4 tx_data", 32'(tx_data), 8'hA2);
        check("t1 c4 tx_src", 32'(tx_src), 0);
        check("t1 c4 grant", 32'(grant), 0);
        check("t1 c4 ready", 32'(req_ready), 0);
        check("t1 c4 busy", 32'(busy), 1);
        next_cycle();
        req_last = 3'b010;
        settle();
        check("t1 c5 grant", 32'(grant), 2);
        check("t1 c5 ready", 32'(req_ready), 2);
        check("t1 c5 tx_valid", 32'(tx_valid), 0);
        next_cycle();
        req_valid = 3'b000;
        req_last  = 3'b000;
        settle();
        check("t1 c6 tx_data", 32'(tx_data), 8'hB0);
        check("t1 c6 tx_src", 32'(tx_src), 1);
        check("t1 c6 grant", 32'(grant), 0);
        next_cycle();
        settle();
        check("t1 c7 tx_valid", 32'(tx_valid), 0);
        check("t1 c7 busy", 32'(busy), 0);
        next_cycle();

        // Test 2: all valid, cap 2, round robin 0,1,2,0
        cap       = 8'd2;
        req_valid = 3'b111;
        req_last  = 3'b000;
        req_data  = {8'h33, 8'h22, 8'h11};
        apply_reset();
        next_cycle();
        for (int k = 0; k < 12; k++) begin
            settle();
            check($sformatf("t2 k%0d grant", k), 32'(grant), t2_grant[k]);
            check($sformatf("t2 k%0d tx_valid", k), 32'(tx_valid), t2_vld[k]);
            if (t2_vld[k] != 0) begin
                check($sformatf("t2 k%0d tx_src", k), 32'(tx_src), t2_src[k]);
                check($sformatf("t2 k%0d tx_data", k), 32'(tx_data), 8'h11 * (t2_src[k] + 1));
            end
            next_cycle();
        end

        // Test 3: tx_ready stall mid-burst
        cap       = '0;
        req_valid = 3'b001;
        req_last  = '0;
        req_data  = '0;
        req_data[7:0] = 8'h40;
        apply_reset();
        next_cycle();
        for (int r = 0; r < 11; r++) begin
            tx_ready      = t3_rdy[r];
            req_data[7:0] = t3_din[r];
            req_last[0]   = t3_last[r];
            req_valid[0]  = t3_val[r];
            settle();
            check($sformatf("t3 r%0d tx_valid", r), 32'(tx_valid), t3_evld[r]);
            check($sformatf("t3 r%0d ready", r), 32'(req_ready), t3_erdy[r]);
            check($sformatf("t3 r%0d grant", r), 32'(grant), t3_egnt[r]);
            if (t3_evld[r] != 0) begin
                check($sformatf("t3 r%0d tx_data", r), 32'(tx_data), t3_edat[r]);
                check($sformatf("t3 r%0d tx_src", r), 32'(tx_src), 0);
            end
            next_cycle();
        end
        tx_ready = 1'b1;

        // Test 4: disable req1 while locked
        cfg_en    = 3'b111;
        req_valid = 3'b010;
        req_last  = '0;
        req_data  = {8'h73, 8'h51, 8'h60};
        apply_reset();
        next_cycle();
        req_valid = 3'b111;
        settle();
        check("t4 c1 grant", 32'(grant), 2);
        check("t4 c1 ready", 32'(req_ready), 2);
        next_cycle();
        cfg_en = 3'b101;
        settle();
        check("t4 c2 ready", 32'(req_ready), 0);
        check("t4 c2 grant", 32'(grant), 2);
        check("t4 c2 tx_data", 32'(tx_data), 8'h51);
        check("t4 c2 tx_src", 32'(tx_src), 1);
        next_cycle();
        settle();
        check("t4 c3 grant", 32'(grant), 0);
        check("t4 c3 ready", 32'(req_ready), 0);
        next_cycle();
        req_last = 3'b100;
        settle();
        check("t4 c4 grant", 32'(grant), 4);
        check("t4 c4 ready", 32'(req_ready), 4);
        next_cycle();
        req_last = 3'b001;
        settle();
        check("t4 c5 grant", 32'(grant), 0);
        check("t4 c5 tx_data", 32'(tx_data), 8'h73);
        check("t4 c5 tx_src", 32'(tx_src), 2);
        next_cycle();
        settle();
        check("t4 c6 grant", 32'(grant), 1);
        check("t4 c6 ready", 32'(req_ready), 1);
        next_cycle();
        req_last = 3'b000;
        settle();
        check("t4 c7 grant", 32'(grant), 0);
        check("t4 c7 tx_data", 32'(tx_data), 8'h60);
        next_cycle();
        settle();
        check("t4 c8 grant", 32'(grant), 4);
        next_cycle();

        // Test 5: async reset mid-burst, pointer returns to favour req0
        cfg_en    = 3'b111;
        req_valid = 3'b001;
        req_last  = 3'b001;
        req_data  = {8'h00, 8'h91, 8'h81};
        apply_reset();
        next_cycle();
        settle();
        check("t5 c1 grant", 32'(grant), 1);
        next_cycle();
        req_valid = 3'b010;
        req_last  = 3'b000;
        settle();
        check("t5 c2 grant", 32'(grant), 0);
        check("t5 c2 tx_data", 32'(tx_data), 8'h81);
        next_cycle();
        settle();
        check("t5 c3 grant", 32'(grant), 2);
        check("t5 c3 ready", 32'(req_ready), 2);
        next_cycle();
        settle();
        check("t5 c4 tx_valid", 32'(tx_valid), 1);
        check("t5 c4 tx_src", 32'(tx_src), 1);
        check("t5 c4 busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_all_zero("t5 async");
        req_valid = 3'b011;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        settle();
        check("t5 after grant", 32'(grant), 1);
        check("t5 after ready", 32'(req_ready), 1);
        next_cycle();

        // Test 6: lone req2, single-byte bursts
        req_valid = 3'b100;
        req_last  = 3'b100;
        req_data  = {8'hC5, 8'h00, 8'h00};
        apply_reset();
        next_cycle();
        nbytes = 0;
        for (int k = 0; k < 8; k++) begin
            settle();
            check($sformatf("t6 k%0d grant", k), 32'(grant), (k % 2 == 0) ? 4 : 0);
            check($sformatf("t6 k%0d tx_valid", k), 32'(tx_valid), k % 2);
            if (tx_valid) begin
                nbytes++;
                check($sformatf("t6 k%0d tx_src", k), 32'(tx_src), 2);
                check($sformatf("t6 k%0d tx_data", k), 32'(tx_data), 8'hC5);
            end
            next_cycle();
        end
        check("t6 byte count", 32'(nbytes), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
